// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a tagged BTB, an IF/ID prediction register and ID-stage training.
// Optional BRANCH_PRED_STATS_EN adds branch and mispredict statistics counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] IF_PC,
    input  logic                ID_Stall,
    input  logic                flush,
    output logic                IF_PredictTaken,
    output logic [PC_WIDTH-1:0] IF_PredictTarget,
    output logic                ID_PredictBranchTaken,
    output logic [PC_WIDTH-1:0] ID_PredictTarget,
    input  logic [PC_WIDTH-1:0] ID_PC,
    input  logic                ID_AttemptBranch,
    input  logic                ID_BranchTaken,
    input  logic [PC_WIDTH-1:0] ID_BranchTarget
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;
    localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

    logic [1:0]          r_cnt    [ENTRIES];
    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];

    logic                r_id_taken;
    logic [PC_WIDTH-1:0] r_id_target;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0]   w_if_tag;
    logic [INDEX_BITS-1:0] w_id_idx;
    logic [TAG_BITS-1:0]   w_id_tag;
    logic                  w_hit;
    logic                  w_update_en;
    logic [1:0]            w_cnt_cur;
    logic [1:0]            w_cnt_next;
    logic                  w_unused;

    assign w_if_idx = IF_PC[INDEX_BITS+1:2];
    assign w_if_tag = IF_PC[TAG_MSB:TAG_LSB];
    assign w_id_idx = ID_PC[INDEX_BITS+1:2];
    assign w_id_tag = ID_PC[TAG_MSB:TAG_LSB];

    // PC bits outside index/tag do not take part in addressing.
    assign w_unused = ^{IF_PC[PC_WIDTH-1:TAG_MSB+1], IF_PC[1:0],
                        ID_PC[PC_WIDTH-1:TAG_MSB+1], ID_PC[1:0]};

    // Reads see pre-update contents; a same-cycle write lands on the next edge.
    assign w_hit            = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign IF_PredictTaken  = w_hit & r_cnt[w_if_idx][1];
    assign IF_PredictTarget = r_target[w_if_idx];

    // Stalled cycles never train; the branch trains once, when it leaves ID.
    assign w_update_en = ID_AttemptBranch & ~ID_Stall;
    assign w_cnt_cur   = r_cnt[w_id_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (ID_BranchTaken) begin
            if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i]    <= 2'b01;
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (w_update_en) begin
            r_cnt[w_id_idx] <= w_cnt_next;
            if (ID_BranchTaken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= ID_BranchTarget;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_taken  <= 1'b0;
            r_id_target <= '0;
        end else if (flush) begin
            r_id_taken  <= 1'b0;
            r_id_target <= '0;
        end else if (!ID_Stall) begin
            r_id_taken  <= IF_PredictTaken;
            r_id_target <= IF_PredictTarget;
        end
    end

    assign ID_PredictBranchTaken = r_id_taken;
    assign ID_PredictTarget      = r_id_target;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_update_en) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (ID_BranchTaken != r_id_taken)
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
